// File: rtl/wall_scheduler.sv
// Wall layout owner and per-frame object/wall overlap sequencer.
// Loads a 4-wall layout and tests one wall per clock after each frame tick.
module wall_scheduler #(
  parameter int NUM_LEVELS = 4,
  parameter int HOR_W      = 64,
  parameter int HOR_H      = 32,
  parameter int VERT_W     = 32,
  parameter int VERT_H     = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [1:0]  level_sel,
  input  logic        level_load,
  input  logic [9:0]  obj_x,
  input  logic [9:0]  obj_y,
  input  logic [9:0]  obj_size,
  output logic [39:0] wall_x,
  output logic [39:0] wall_y,
  output logic [3:0]  wall_vert,
  output logic [3:0]  hit_mask,
  output logic        hit_any,
  output logic        check_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

  localparam logic [39:0] L0X =
    {10'd600, 10'd320, 10'd400, 10'd10};
  localparam logic [39:0] L0Y =
    {10'd400, 10'd240, 10'd200, 10'd20};
  localparam logic [3:0]  L0V = 4'b1010;

  // Entry is {x, y, vertical}; out-of-range levels fall back to layout 0.
  function automatic logic [20:0] layout(
    input logic [1:0] lvl,
    input logic [1:0] i
  );
    logic [1:0]  l;
    logic [20:0] r;
    l = lvl;
    if (int'(lvl) >= NUM_LEVELS) l = 2'd0;
    r = '0;
    case ({l, i})
      4'h0: r = {10'd10,  10'd20,  1'b0};
      4'h1: r = {10'd400, 10'd200, 1'b1};
      4'h2: r = {10'd320, 10'd240, 1'b0};
      4'h3: r = {10'd600, 10'd400, 1'b1};
      4'h4: r = {10'd100, 10'd100, 1'b1};
      4'h5: r = {10'd200, 10'd300, 1'b0};
      4'h6: r = {10'd500, 10'd50,  1'b1};
      4'h7: r = {10'd50,  10'd420, 1'b0};
      4'h8: r = {10'd0,   10'd0,   1'b0};
      4'h9: r = {10'd575, 10'd0,   1'b0};
      4'ha: r = {10'd0,   10'd447, 1'b0};
      4'hb: r = {10'd575, 10'd447, 1'b0};
      4'hc: r = {10'd300, 10'd100, 1'b1};
      4'hd: r = {10'd300, 10'd316, 1'b1};
      4'he: r = {10'd150, 10'd224, 1'b0};
      4'hf: r = {10'd426, 10'd224, 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  lvl_q;
  logic        frame_q;
  logic [9:0]  ox_q, oy_q, osz_q;
  logic [3:0]  acc_q;
  logic [3:0]  hit_mask_q;
  logic        hit_any_q;
  logic [39:0] wx_q, wy_q;
  logic [3:0]  wv_q;

  logic        rise;
  logic        start_load, start_chk;
  logic [20:0] lay_w;
  logic [10:0] cwx, cwy, cw, ch;
  logic [10:0] ox_l, oy_l, ox_h, oy_h;
  logic        cv, hit_cur;

  assign rise = frame_clk & ~frame_q;
  assign lay_w = layout(lvl_q, idx_q);

  assign cwx  = {1'b0, wx_q[idx_q*10 +: 10]};
  assign cwy  = {1'b0, wy_q[idx_q*10 +: 10]};
  assign cv   = wv_q[idx_q];
  assign cw   = cv ? 11'(VERT_W) : 11'(HOR_W);
  assign ch   = cv ? 11'(VERT_H) : 11'(HOR_H);
  assign ox_l = {1'b0, ox_q};
  assign oy_l = {1'b0, oy_q};
  assign ox_h = ox_l + {1'b0, osz_q};
  assign oy_h = oy_l + {1'b0, osz_q};

  // Inclusive edges: touching boxes count as a hit.
  assign hit_cur = (ox_l <= cwx + cw) && (cwx <= ox_h) &&
                   (oy_l <= cwy + ch) && (cwy <= oy_h);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start_load = 1'b0;
    start_chk  = 1'b0;
    check_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_load) begin
          state_d    = LOAD;
          idx_d      = 2'd0;
          start_load = 1'b1;
        end else if (rise) begin
          state_d   = CHECK;
          idx_d     = 2'd0;
          start_chk = 1'b1;
        end
      end
      LOAD: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      CHECK: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        check_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      lvl_q      <= 2'd0;
      frame_q    <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      osz_q      <= '0;
      acc_q      <= '0;
      hit_mask_q <= '0;
      hit_any_q  <= 1'b0;
      wx_q       <= L0X;
      wy_q       <= L0Y;
      wv_q       <= L0V;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_clk;
      if (start_load) begin
        lvl_q      <= level_sel;
        hit_mask_q <= '0;
        hit_any_q  <= 1'b0;
      end
      if (start_chk) begin
        ox_q  <= obj_x;
        oy_q  <= obj_y;
        osz_q <= obj_size;
        acc_q <= '0;
      end
      if (state_q == LOAD) begin
        wx_q[idx_q*10 +: 10] <= lay_w[20:11];
        wy_q[idx_q*10 +: 10] <= lay_w[10:1];
        wv_q[idx_q]          <= lay_w[0];
      end
      if (state_q == CHECK) acc_q[idx_q] <= hit_cur;
      if (state_q == DONE) begin
        hit_mask_q <= acc_q;
        hit_any_q  <= |acc_q;
      end
    end
  end

  assign wall_x    = wx_q;
  assign wall_y    = wy_q;
  assign wall_vert = wv_q;
  assign hit_mask  = hit_mask_q;
  assign hit_any   = hit_any_q;
  assign busy      = (state_q != IDLE);

endmodule
